mcu_spi_link: RTL and testbench

- Parametrised MCU link: built-in SPI mode-0 slave plus TX command queue and RX frame decoder.
- Frame is {cmd[7:0], addr[7:0], data[DATA_W-1:0]}, MSB first, full duplex.
- Adds multi-channel round-robin TX arbitration, configurable data width and queue depth, back-to-back frames within one CS, and retransmission of frames aborted by CS deassert.
- Sits between the MCU SPI pins and the command dispatch logic of the core.

---
 rtl/mcu_spi_link.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mcu_spi_link.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_spi_link.sv
// Purpose: SPI mode-0 slave link to the MCU. A TX command queue is fed by round-robin channels, and an RX frame decoder sits on the receive side.
// Latency: rx_valid/tx_sent appear about 3 clk after the last SCK rise (2-flop sync plus edge detect); MSB out about 3 clk after CS falls.
// Backpressure: a full queue withholds tx_ack so requests wait; the SPI side never stalls and sends a NOP frame when the queue is empty.
//
// Ports:
//   clk, reset                 system clock (>= 4x SCK), synchronous active-high reset
//   spi_sck/cs_n/mosi/miso     MCU SPI pins; the inputs are asynchronous
//   rx_cmd/addr/data, rx_valid last received frame, with a one-cycle strobe
//   busy                       set by INIT_START_CMD, cleared by INIT_DONE_CMD
//   tx_req/tx_frame/tx_ack     per-channel frame requests and a one-hot grant pulse
//   q_level, tx_sent           queue occupancy; pulse when a queued frame finishes on the wire
module mcu_spi_link #(
  parameter int          DATA_W         = 8,
  parameter int          NCH            = 4,
  parameter int          QDEPTH_LOG2    = 4,
  parameter logic [7:0]  NOP_CMD        = 8'hFF,
  parameter logic [7:0]  INIT_START_CMD = 8'hFD,
  parameter logic [7:0]  INIT_DONE_CMD  = 8'hFE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_sck,
  input  logic                     spi_cs_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic [7:0]               rx_cmd,
  output logic [7:0]               rx_addr,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     rx_valid,
  output logic                     busy,
  input  logic [NCH-1:0]           tx_req,
  input  logic [NCH*(16+DATA_W)-1:0] tx_frame,
  output logic [NCH-1:0]           tx_ack,
  output logic [QDEPTH_LOG2:0]     q_level,
  output logic                     tx_sent
);

  localparam int FW     = 16 + DATA_W;
  localparam int QDEPTH = 1 << QDEPTH_LOG2;
  localparam int CW     = $clog2(FW + 1);
  localparam int PW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int QCW    = QDEPTH_LOG2 + 1;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [2:0] sck_q;
  logic [1:0] cs_q;
  logic       cs_d;
  logic [1:0] mosi_q;

  // The CS chain resets to 0 ("low"). A falling edge therefore needs CS to be
  // seen high first. This stops a link reset mid-frame from restarting
  // reception while the MCU still holds CS low.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q  <= '0;
      cs_q   <= '0;
      cs_d   <= 1'b0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_q   <= {cs_q[0], spi_cs_n};
      cs_d   <= cs_q[1];
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_high;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_fall  = cs_d & ~cs_q[1];
  assign cs_high  = cs_q[1];

  // ---------------------------------------------------------------------------
  // Frame control
  // ---------------------------------------------------------------------------
  logic              in_frame;
  logic [CW-1:0]     bit_cnt;
  logic [FW-1:0]     tx_sh;
  logic [FW-2:0]     rx_sh;
  logic [FW-1:0]     rx_word;
  logic              hold_vld;
  logic [FW-1:0]     hold_dat;

  logic              frame_start;
  logic              sample_bit;
  logic              shift_bit;
  logic              frame_done;

  // The queue signals are declared here because frame start pops the queue.
  logic [FW-1:0]     q_mem [QDEPTH];
  logic [QDEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [QCW-1:0]    q_cnt;
  logic              q_full, q_empty;
  logic [FW-1:0]     q_head;
  logic              push, pop;

  assign q_full  = (q_cnt == QCW'(QDEPTH));
  assign q_empty = (q_cnt == '0);
  assign q_head  = q_mem[rd_ptr];

  // A frame starts on CS falling, or back-to-back on the SCK fall that
  // follows the FW-th rise while CS stays low.
  assign frame_start = cs_fall |
                       (in_frame & ~cs_high & sck_fall & (bit_cnt == CW'(FW)));
  assign sample_bit  = in_frame & ~cs_high & sck_rise & (bit_cnt < CW'(FW));
  // MSB is already on the pin at frame start. Falls after rises 1..FW-1
  // advance to the next bit.
  assign shift_bit   = in_frame & ~cs_high & sck_fall &
                       (bit_cnt != '0) & (bit_cnt < CW'(FW));
  assign frame_done  = sample_bit & (bit_cnt == CW'(FW - 1));
  assign rx_word     = {rx_sh, mosi_q[1]};

  // The hold register follows the current non-NOP outgoing frame from
  // frame start until it completes. An aborted frame therefore stays in the
  // hold register, and it is preferred over the queue at the next start.
  assign pop = frame_start & ~hold_vld & ~q_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame <= 1'b0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else begin
      if (frame_start) begin
        in_frame <= 1'b1;
        bit_cnt  <= '0;
        if (hold_vld) begin
          tx_sh <= hold_dat;
        end else if (!q_empty) begin
          tx_sh    <= q_head;
          hold_dat <= q_head;
          hold_vld <= 1'b1;
        end else begin
          tx_sh <= {NOP_CMD, {(FW-8){1'b0}}};
        end
      end else if (in_frame && cs_high) begin
        // CS went high: any partial RX is dropped and hold_vld is kept.
        in_frame <= 1'b0;
      end else begin
        if (sample_bit) begin
          rx_sh   <= rx_word[FW-2:0];
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (shift_bit) begin
          tx_sh <= {tx_sh[FW-2:0], 1'b0};
        end
        if (frame_done && hold_vld) begin
          hold_vld <= 1'b0;
        end
      end
    end
  end

  assign spi_miso = in_frame & tx_sh[FW-1];

  // ---------------------------------------------------------------------------
  // RX capture, busy flag, sent pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cmd   <= '0;
      rx_addr  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      tx_sent  <= 1'b0;
    end else begin
      rx_valid <= frame_done;
      tx_sent  <= frame_done & hold_vld;
      if (frame_done) begin
        rx_cmd  <= rx_word[DATA_W+8 +: 8];
        rx_addr <= rx_word[DATA_W +: 8];
        rx_data <= rx_word[DATA_W-1:0];
        if (rx_word[DATA_W+8 +: 8] == INIT_START_CMD) begin
          busy <= 1'b1;
        end else if (rx_word[DATA_W+8 +: 8] == INIT_DONE_CMD) begin
          busy <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter. The grant is combinational, so tx_ack is seen in the
  // same cycle that the frame is pushed.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]  rr_ptr;
  logic           found_hi, found_lo;
  logic [PW-1:0]  hi_idx, lo_idx;
  logic           gnt_vld;
  logic [PW-1:0]  gnt_idx;
  logic [FW-1:0]  gnt_frame;

  // The first pass looks at channels at or above the pointer, and the second
  // pass wraps to the channels below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = 0; j < NCH; j++) begin
      if (!found_hi && tx_req[j] && (PW'(j) >= rr_ptr)) begin
        found_hi = 1'b1;
        hi_idx   = PW'(j);
      end
      if (!found_lo && tx_req[j]) begin
        found_lo = 1'b1;
        lo_idx   = PW'(j);
      end
    end
    gnt_vld = (found_hi | found_lo) & ~q_full & ~reset;
    gnt_idx = found_hi ? hi_idx : lo_idx;
  end

  always_comb begin
    gnt_frame = '0;
    tx_ack    = '0;
    for (int j = 0; j < NCH; j++) begin
      if (gnt_idx == PW'(j)) begin
        gnt_frame = tx_frame[j*FW +: FW];
      end
      tx_ack[j] = gnt_vld & (gnt_idx == PW'(j));
    end
  end

  assign push = gnt_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= gnt_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  assign q_level = q_cnt;

endmodule

// File: tb/tb_mcu_spi_link.sv
module tb_mcu_spi_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic spi_sck, spi_mosi, cs8_n, cs16_n;

  // DATA_W = 8, NCH = 4 instance
  logic        miso8, rx_valid8, busy8, tx_sent8;
  logic [7:0]  rx_cmd8, rx_addr8, rx_data8;
  logic [3:0]  tx_req8, tx_ack8;
  logic [95:0] tx_frame8;
  logic [4:0]  q_level8;

  // DATA_W = 16, NCH = 2 instance
  logic        miso16, rx_valid16, busy16, tx_sent16;
  logic [7:0]  rx_cmd16, rx_addr16;
  logic [15:0] rx_data16;
  logic [1:0]  tx_req16, tx_ack16;
  logic [63:0] tx_frame16;
  logic [4:0]  q_level16;

  mcu_spi_link dut8 (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(cs8_n),
    .spi_mosi(spi_mosi), .spi_miso(miso8), .rx_cmd(rx_cmd8), .rx_addr(rx_addr8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8), .tx_req(tx_req8),
    .tx_frame(tx_frame8), .tx_ack(tx_ack8), .q_level(q_level8), .tx_sent(tx_sent8)
  );

  mcu_spi_link #(.DATA_W(16), .NCH(2)) dut16 (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(cs16_n),
    .spi_mosi(spi_mosi), .spi_miso(miso16), .rx_cmd(rx_cmd16), .rx_addr(rx_addr16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .busy(busy16), .tx_req(tx_req16),
    .tx_frame(tx_frame16), .tx_ack(tx_ack16), .q_level(q_level16), .tx_sent(tx_sent16)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sent8 = 0;
  int sent16 = 0;
  logic arb_run = 1'b0;

  logic [31:0] exp_rx8[$], exp_rx16[$];
  logic [31:0] exp_miso8[$], act_miso8[$], exp_miso16[$], act_miso16[$];
  logic [3:0]  exp_ack8[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h, expected nothing", name, act);
  endtask

  // ---------------- monitors (scoreboard side) ----------------
  always @(negedge clk) begin
    if (rx_valid8) begin
      if (exp_rx8.size() == 0) flag("rx8 unexpected", {8'h0, rx_cmd8, rx_addr8, rx_data8});
      else check("rx8 frame", {8'h0, rx_cmd8, rx_addr8, rx_data8}, exp_rx8.pop_front());
    end
    if (rx_valid16) begin
      if (exp_rx16.size() == 0) flag("rx16 unexpected", {rx_cmd16, rx_addr16, rx_data16});
      else check("rx16 frame", {rx_cmd16, rx_addr16, rx_data16}, exp_rx16.pop_front());
    end
    if (act_miso8.size() > 0 && exp_miso8.size() > 0)
      check("miso8 frame", act_miso8.pop_front(), exp_miso8.pop_front());
    if (act_miso16.size() > 0 && exp_miso16.size() > 0)
      check("miso16 frame", act_miso16.pop_front(), exp_miso16.pop_front());
    if (tx_ack8 != 4'b0) begin
      if (exp_ack8.size() == 0) flag("ack8 unexpected", {28'h0, tx_ack8});
      else check("ack8 grant", {28'h0, tx_ack8}, {28'h0, exp_ack8.pop_front()});
    end
    if (tx_ack16 != 2'b0) flag("ack16 unexpected", {30'h0, tx_ack16});
    if (tx_sent8) sent8++;
    if (tx_sent16) sent16++;
  end

  // ---------------- SPI master ----------------
  task automatic spi_bits(input int sel, input int nbits, input logic [31:0] word,
                          output logic [31:0] got);
    got = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = word[i];
      #50 spi_sck = 1'b1;
      got = {got[30:0], (sel == 0) ? miso8 : miso16};
      #50 spi_sck = 1'b0;
    end
  endtask

  task automatic cs_set(input int sel, input logic v);
    @(negedge clk);
    #50;
    if (sel == 0) cs8_n = v;
    else cs16_n = v;
    #100;
  endtask

  task automatic xfer(input int sel, input int fw, input logic [31:0] word,
                      input logic [31:0] exp_miso);
    logic [31:0] got;
    if (sel == 0) begin
      exp_rx8.push_back(word);
      exp_miso8.push_back(exp_miso);
    end else begin
      exp_rx16.push_back(word);
      exp_miso16.push_back(exp_miso);
    end
    spi_bits(sel, fw, word, got);
    if (sel == 0) act_miso8.push_back(got);
    else act_miso16.push_back(got);
  endtask

  // ---------------- TX requesters ----------------
  task automatic req_one(input int ch, input logic [23:0] frame, input logic [3:0] exp);
    logic got;
    exp_ack8.push_back(exp);
    tx_frame8[ch*24 +: 24] = frame;
    @(posedge clk); #1;
    tx_req8[ch] = 1'b1;
    #1;
    got = tx_ack8[ch];
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #2;
      got = tx_ack8[ch];
    end
    if (!got) flag("ack8 timeout", {28'h0, tx_ack8});
    @(posedge clk); #1;
    tx_req8[ch] = 1'b0;
  endtask

  // Every channel requests all the time. A channel drops its request for one
  // cycle after it is acknowledged, then raises it again.
  task automatic arb_driver();
    logic [3:0] drop;
    drop = 4'b0;
    while (arb_run) begin
      @(posedge clk); #1;
      tx_req8 = 4'hF & ~drop;
      #1;
      drop = tx_ack8;
    end
    tx_req8 = 4'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    spi_sck = 1'b0; spi_mosi = 1'b0; cs8_n = 1'b1; cs16_n = 1'b1;
    tx_req8 = '0; tx_frame8 = '0; tx_req16 = '0; tx_frame16 = '0;

    // Reset state
    do_reset();
    check("reset rx fields", {8'h0, rx_cmd8, rx_addr8, rx_data8}, 32'h0);
    check("reset rx_valid", {31'h0, rx_valid8}, 32'h0);
    check("reset busy", {31'h0, busy8}, 32'h0);
    check("reset tx_ack", {28'h0, tx_ack8}, 32'h0);
    check("reset tx_sent", {31'h0, tx_sent8}, 32'h0);
    check("reset miso", {31'h0, miso8}, 32'h0);
    check("reset q_level", {27'h0, q_level8}, 32'h0);
    @(negedge clk) reset = 1'b0;

    // Single frame with an empty queue: the reply is the NOP filler
    cs_set(0, 1'b0);
    xfer(0, 24, 32'h01035A, 32'hFF0000);
    cs_set(0, 1'b1);
    check("sent after NOP", sent8, 0);

    // One queued frame on channel 2
    req_one(2, 24'hFC0041, 4'b0100);
    repeat (2) @(posedge clk); #1;
    check("q_level after push", {27'h0, q_level8}, 32'd1);
    cs_set(0, 1'b0);
    xfer(0, 24, 32'h102030, 32'hFC0041);
    cs_set(0, 1'b1);
    check("sent after queued", sent8, 1);
    check("q_level after pop", {27'h0, q_level8}, 32'd0);

    // Abort after 10 bits, then retransmit. The RR pointer is 3, so ch0 wins.
    req_one(0, 24'hFA0C12, 4'b0001);
    repeat (2) @(posedge clk); #1;
    check("q_level abort push", {27'h0, q_level8}, 32'd1);
    cs_set(0, 1'b0);
    spi_bits(0, 10, 32'h3FF, got);
    cs_set(0, 1'b1);
    check("abort partial miso", got, 32'h3E8);
    check("sent after abort", sent8, 1);
    check("q_level in hold", {27'h0, q_level8}, 32'd0);
    cs_set(0, 1'b0);
    xfer(0, 24, 32'h223344, 32'hFA0C12);
    cs_set(0, 1'b1);
    check("sent after resend", sent8, 2);

    // Three back-to-back frames under one CS
    cs_set(0, 1'b0);
    xfer(0, 24, 32'hFD0000, 32'hFF0000);
    check("busy after start", {31'h0, busy8}, 32'd1);
    xfer(0, 24, 32'h010011, 32'hFF0000);
    check("busy after other", {31'h0, busy8}, 32'd1);
    xfer(0, 24, 32'hFE0000, 32'hFF0000);
    check("busy after done", {31'h0, busy8}, 32'd0);
    cs_set(0, 1'b1);
    check("sent after b2b", sent8, 2);

    // Round-robin fill to full, starting from a fresh reset (pointer 0)
    do_reset();
    @(negedge clk) reset = 1'b0;
    tx_frame8 = {24'hC30003, 24'hC20002, 24'hC10001, 24'hC00000};
    for (int k = 0; k < 16; k++) exp_ack8.push_back(4'b0001 << (k % 4));
    arb_run = 1'b1;
    fork
      arb_driver();
    join_none
    repeat (30) @(posedge clk); #1;
    check("q_level full", {27'h0, q_level8}, 32'd16);
    check("acks seen at full", exp_ack8.size(), 0);
    // The CS-fall start pops ch0's frame. The trailing SCK fall then starts
    // the next frame, which pops ch1's frame into hold. Each pop frees one
    // slot, granted in turn to ch0 and then ch1.
    exp_ack8.push_back(4'b0001);
    exp_ack8.push_back(4'b0010);
    cs_set(0, 1'b0);
    xfer(0, 24, 32'h050607, 32'hC00000);
    cs_set(0, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("q_level refilled", {27'h0, q_level8}, 32'd16);
    arb_run = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("sent after rr pop", sent8, 3);

    // DATA_W = 16 instance: one frame, then a reset in the middle of a frame
    cs_set(1, 1'b0);
    xfer(1, 32, 32'h0201ABCD, 32'hFF000000);
    spi_bits(1, 12, 32'hFFF, got);
    @(posedge clk); #1;
    do_reset();
    check("rst16 rx fields", {rx_cmd16, rx_addr16, rx_data16}, 32'h0);
    check("rst16 rx_valid", {31'h0, rx_valid16}, 32'h0);
    check("rst16 busy/sent", {30'h0, busy16, tx_sent16}, 32'h0);
    check("rst16 miso", {31'h0, miso16}, 32'h0);
    check("rst16 q_level", {27'h0, q_level16}, 32'h0);
    @(negedge clk) reset = 1'b0;
    // CS is still low: these bits must not produce a frame
    spi_bits(1, 20, 32'h0, got);
    spi_bits(1, 32, 32'h0201ABCD, got);
    cs_set(1, 1'b1);
    cs_set(1, 1'b0);
    xfer(1, 32, 32'h03041234, 32'hFF000000);
    cs_set(1, 1'b1);
    check("sent16 count", sent16, 0);

    repeat (10) @(posedge clk); #1;
    check("rx8 pending", exp_rx8.size(), 0);
    check("rx16 pending", exp_rx16.size(), 0);
    check("miso8 pending", exp_miso8.size(), 0);
    check("miso16 pending", exp_miso16.size(), 0);
    check("ack8 pending", exp_ack8.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
